hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline. Detects load-use
//  hazards and stalls IF/ID, selects EX-stage operand forwarding, and flushes
//  wrong-path stages when a branch resolves taken in MEM (MEM_PCSrc). Sits beside
//  the stage blocks; its outputs gate PC/IF_ID writes, ID/EX bubbles and the flushes.
// PARAMETERS
//  LOAD_STALL   1   cycles held per load-use hazard (>=1; >1 models slow dmem)
//  FLUSH_CYCLES 1   cycles flush outputs stay high per taken branch (>=1)
//  CNT_W        16  width of the saturating stall/flush event counters
// PORTS
//  clk            in   1      pipeline clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  ifid_rs        in   5      rs field of instr in IF/ID
//  ifid_rt        in   5      rt field of instr in IF/ID
//  idex_memread   in   1      ID/EX instr is a load
//  idex_rs        in   5      ID/EX rs (forwarding compare)
//  idex_rt        in   5      ID/EX rt (load dest, forwarding compare)
//  exmem_rd       in   5      EX/MEM dest reg (five_bit_muxout)
//  exmem_regwrite in   1      EX/MEM writes register file
//  memwb_rd       in   5      MEM/WB dest reg
//  memwb_regwrite in   1      MEM/WB writes register file
//  mem_pcsrc      in   1      branch taken, resolved in MEM this cycle
//  pc_write       out  1      1 = PC may update
//  ifid_write     out  1      1 = IF/ID may load
//  idex_bubble    out  1      1 = zero ID/EX control fields (insert nop)
//  ifid_flush     out  1      clear IF/ID
//  idex_flush     out  1      clear ID/EX
//  exmem_flush    out  1      clear EX/MEM control (wrong-path instr in EX)
//  fwd_a          out  2      ALU operand A select
//  fwd_b          out  2      ALU operand B select
//  stall_cnt      out  CNT_W  stall cycles taken, saturating
//  flush_cnt      out  CNT_W  taken-branch flush events, saturating
//  state          out  2      FSM state (debug)
// BEHAVIOUR
//  - Reset (rst_n low, async): state=RUN, internal counter=0, stall_cnt=flush_cnt=0;
//    while low, outputs forced: pc_write=1, ifid_write=1, bubble/flushes=0, fwd=00.
//  - load_use = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
//  - States RUN=0, STALL=1, FLUSH=2. Hazard/flush controls are same-cycle (Mealy)
//    on inputs, plus Moore hold from STALL/FLUSH.
//  - RUN, load_use, no mem_pcsrc: pc_write=0, ifid_write=0, idex_bubble=1 this cycle;
//    stall_cnt+1; if LOAD_STALL>1 -> STALL, cnt=LOAD_STALL-1.
//  - STALL: same outputs; stall_cnt+1 per cycle; cnt-1; cnt==1 -> RUN next edge.
//  - mem_pcsrc (any state) has priority: ifid_flush=idex_flush=exmem_flush=1,
//    pc_write=1, ifid_write=1, idex_bubble=0; any stall aborted, not counted;
//    flush_cnt+1; FLUSH_CYCLES>1 -> FLUSH, cnt=FLUSH_CYCLES-1, else RUN.
//  - FLUSH: flushes held, pc_write=ifid_write=1; load_use ignored; cnt==1 -> RUN.
//    mem_pcsrc during FLUSH restarts count, flush_cnt+1.
//  - Forwarding (always active, all states): fwd_a=10 if exmem_regwrite &
//    exmem_rd!=0 & exmem_rd==idex_rs; else 01 if memwb_regwrite & memwb_rd!=0 &
//    memwb_rd==idex_rs; else 00. fwd_b identical on idex_rt. EX/MEM beats MEM/WB.
//  - Counters saturate at all-ones, never wrap. State 3 unreachable -> RUN.
// STRUCTURE
//  - pipeline_pkg: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; ST_RUN/ST_STALL/
//    ST_FLUSH encodings; REG_ZERO=5'd0.
//  - Sub-module forward_unit (combinational fwd_a/fwd_b); FSM, hazard detect and
//    counters in hazard_ctrl.
// TESTING
//  1 idex_memread=1, idex_rt=2, ifid_rs=2 -> 1 cycle pc_write=0, ifid_write=0,
//    idex_bubble=1, stall_cnt 0->1; idex_rt=0 same case -> no stall.
//  2 exmem_rd=memwb_rd=idex_rs=5, both regwrite -> fwd_a=10; drop exmem_regwrite
//    -> 01; all rd=0 -> 00; idex_rt=5 mirrors on fwd_b.
//  3 load_use and mem_pcsrc same cycle -> all flushes=1, pc_write=1, bubble=0,
//    stall_cnt unchanged, flush_cnt+1, state RUN.
//  4 LOAD_STALL=3, FLUSH_CYCLES=2: load_use -> 3 stall cycles, state 0,1,1,0;
//    mem_pcsrc pulse -> flushes high 2 cycles, state 2 then 0; pcsrc mid-STALL aborts.
//  5 rst_n low during STALL/FLUSH -> outputs at reset values immediately, state=0,
//    counters 0; release -> normal RUN next edge.
//  6 CNT_W=4, 20 stall cycles -> stall_cnt holds 4'hF, no wrap.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Purpose: shared types and constants for the pipeline sequencing controller.
//   FWD_*    : ALU operand source selects (register file, MEM/WB, EX/MEM)
//   state_e  : hazard controller FSM encoding
//   hz_ctrl_t: bundle of pipeline gating/flush controls driven by hazard_ctrl
//   fwd_sel  : forwarding priority rule for one EX-stage source register
package pipeline_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } hz_ctrl_t;

  // Free-running pipeline, load-use hold, and wrong-path flush control sets.
  localparam hz_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                                      ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
  localparam hz_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                      ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                                      ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1};

  // EX/MEM result is newer than MEM/WB, so it wins when both match; r0 never forwards.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] ex_rd,
    input logic             ex_we,
    input logic [REG_W-1:0] wb_rd,
    input logic             wb_we
  );
    if (ex_we && (ex_rd != REG_ZERO) && (ex_rd == src)) return FWD_MEM;
    if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == src)) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Purpose: combinational EX-stage operand forwarding select.
//   idex_rs/idex_rt            : source registers of the instruction in EX
//   exmem_rd/exmem_regwrite    : destination/write-enable one stage ahead
//   memwb_rd/memwb_regwrite    : destination/write-enable two stages ahead
//   fwd_a/fwd_b                : ALU operand A/B source select
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_regwrite,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b
);

  assign fwd_a = fwd_sel(idex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
  assign fwd_b = fwd_sel(idex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline sequencing controller: load-use stall, taken-branch flush,
//   operand forwarding selects and saturating stall/flush event counters.
//   clk, rst_n                   : clock (rising edge), async active-low reset
//   ifid_rs/ifid_rt              : source registers of the instruction in IF/ID
//   idex_memread/idex_rs/idex_rt : load flag and registers of the instruction in ID/EX
//   exmem_rd/exmem_regwrite      : EX/MEM destination and write enable
//   memwb_rd/memwb_regwrite      : MEM/WB destination and write enable
//   mem_pcsrc                    : branch resolved taken in MEM this cycle
//   pc_write/ifid_write          : allow PC / IF/ID to update
//   idex_bubble                  : insert a nop into ID/EX
//   ifid_flush/idex_flush/exmem_flush : squash wrong-path instructions
//   fwd_a/fwd_b                  : ALU operand selects
//   stall_cnt/flush_cnt          : saturating event counters
//   state                        : FSM state for debug
// Gating/flush/forwarding outputs react to inputs in the same cycle.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             mem_pcsrc,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  // Hold counter only ever stores (hold length - 1).
  localparam int unsigned MAX_HOLD = (LOAD_STALL > FLUSH_CYCLES) ? LOAD_STALL : FLUSH_CYCLES;
  localparam int unsigned CW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

  state_e           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             load_use;
  hz_ctrl_t         ctrl;
  logic [FWD_W-1:0] fwd_a_raw, fwd_b_raw;

  forward_unit u_fwd (
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .fwd_a          (fwd_a_raw),
    .fwd_b          (fwd_b_raw)
  );

  assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // Next state, hold counter and same-cycle controls; taken branch overrides everything.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    ctrl      = CTRL_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (mem_pcsrc) begin
      ctrl      = CTRL_FLUSH;
      flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = ST_FLUSH;
        cnt_n   = CW'(FLUSH_CYCLES - 1);
      end else begin
        state_n = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use) begin
            ctrl      = CTRL_STALL;
            stall_inc = 1'b1;
            if (LOAD_STALL > 1) begin
              state_n = ST_STALL;
              cnt_n   = CW'(LOAD_STALL - 1);
            end
          end
        end
        ST_STALL: begin
          ctrl      = CTRL_STALL;
          stall_inc = 1'b1;
          if (cnt_q == CW'(1)) state_n = ST_RUN;
          else                 cnt_n   = cnt_q - CW'(1);
        end
        ST_FLUSH: begin
          ctrl = CTRL_FLUSH;
          if (cnt_q == CW'(1)) state_n = ST_RUN;
          else                 cnt_n   = cnt_q - CW'(1);
        end
        default: state_n = ST_RUN;
      endcase
    end
    if (!rst_n) ctrl = CTRL_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_bubble = ctrl.idex_bubble;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign fwd_a       = rst_n ? fwd_a_raw : FWD_REG;
  assign fwd_b       = rst_n ? fwd_b_raw : FWD_REG;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default parameters, and LOAD_STALL=3,
// FLUSH_CYCLES=2, CNT_W=4) share all inputs and are compared every cycle
// against a cycle-count reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
  logic       idex_memread, exmem_regwrite, memwb_regwrite, mem_pcsrc;

  logic       a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf;
  logic [1:0] a_fa, a_fb, a_st;
  logic [15:0] a_sc, a_fc;
  logic       b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf;
  logic [1:0] b_fa, b_fb, b_st;
  logic [3:0] b_sc, b_fc;

  int total = 0;
  int bad   = 0;

  // Reference model: remaining stall / flush cycles and event counts per instance.
  int m_sl [2];
  int m_fl [2];
  int m_sc [2];
  int m_fc [2];

  logic [43:0] obs [2];
  logic [43:0] e0, e1;

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .mem_pcsrc(mem_pcsrc),
    .pc_write(a_pcw), .ifid_write(a_ifw), .idex_bubble(a_bub),
    .ifid_flush(a_iff), .idex_flush(a_idf), .exmem_flush(a_exf),
    .fwd_a(a_fa), .fwd_b(a_fb), .stall_cnt(a_sc), .flush_cnt(a_fc), .state(a_st)
  );

  hazard_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .mem_pcsrc(mem_pcsrc),
    .pc_write(b_pcw), .ifid_write(b_ifw), .idex_bubble(b_bub),
    .ifid_flush(b_iff), .idex_flush(b_idf), .exmem_flush(b_exf),
    .fwd_a(b_fa), .fwd_b(b_fb), .stall_cnt(b_sc), .flush_cnt(b_fc), .state(b_st)
  );

  assign obs[0] = {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_exf, a_fa, a_fb, a_st, a_sc, a_fc};
  assign obs[1] = {b_pcw, b_ifw, b_bub, b_iff, b_idf, b_exf, b_fa, b_fb, b_st,
                   12'd0, b_sc, 12'd0, b_fc};

  function automatic int p_ls(int k);  return (k == 0) ? 1 : 3;      endfunction
  function automatic int p_fc(int k);  return (k == 0) ? 1 : 2;      endfunction
  function automatic int p_max(int k); return (k == 0) ? 65535 : 15; endfunction

  function automatic bit ref_load_use();
    return idex_memread && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] src);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == src) return 2'b10;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected output vector for the current cycle, before the next edge.
  function automatic logic [43:0] model_exp(int k);
    logic pcw, ifw, bub;
    logic [2:0] fl;
    logic [1:0] st;
    if (!rst_n) return {3'b110, 3'b000, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0};
    pcw = 1'b1; ifw = 1'b1; bub = 1'b0; fl = 3'b000;
    if (mem_pcsrc || m_fl[k] > 0) fl = 3'b111;
    else if (m_sl[k] > 0 || ref_load_use()) begin
      pcw = 1'b0; ifw = 1'b0; bub = 1'b1;
    end
    st = (m_fl[k] > 0) ? 2'd2 : (m_sl[k] > 0) ? 2'd1 : 2'd0;
    return {pcw, ifw, bub, fl, ref_fwd(idex_rs), ref_fwd(idex_rt), st,
            16'(m_sc[k]), 16'(m_fc[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sl[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // Advance the model across a rising edge using the inputs held at that edge.
  task automatic clock_edge();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (mem_pcsrc) begin
          if (m_fc[k] < p_max(k)) m_fc[k]++;
          m_fl[k] = p_fc(k) - 1;
          m_sl[k] = 0;
        end else if (m_fl[k] > 0) begin
          m_fl[k]--;
        end else if (m_sl[k] > 0 || ref_load_use()) begin
          if (m_sc[k] < p_max(k)) m_sc[k]++;
          m_sl[k] = (m_sl[k] > 0) ? m_sl[k] - 1 : p_ls(k) - 1;
        end
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    ifid_rs = 0; ifid_rt = 0; idex_memread = 0; idex_rs = 0; idex_rt = 0;
    exmem_rd = 0; exmem_regwrite = 0; memwb_rd = 0; memwb_regwrite = 0; mem_pcsrc = 0;
  endtask

  task automatic drive_load_use(bit pcsrc);
    drive_idle();
    idex_memread = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2; mem_pcsrc = pcsrc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; idex_rs = 5'd5; idex_rt = 5'd5;
    idex_memread = 1'b1; ifid_rs = 5'd5; mem_pcsrc = 1'b1;
    #2;
    e0 = model_exp(0); e1 = model_exp(1); total += 2;
    if (obs[0] !== e0) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs[0], e0); end
    if (obs[1] !== e1) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs[1], e1); end
    clock_edge();
    drive_idle();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e0 = model_exp(0); e1 = model_exp(1); total += 2;
      if (obs[0] !== e0) begin bad++; $display("FAIL after_reset_a c%0d got=%h exp=%h", c, obs[0], e0); end
      if (obs[1] !== e1) begin bad++; $display("FAIL after_reset_b c%0d got=%h exp=%h", c, obs[1], e1); end
      clock_edge();
    end
  endtask

  // One load-use cycle, then an r0 "load" that must not stall, then an rt-side match.
  task automatic test_load_use();
    for (int c = 0; c < 12; c++) begin
      drive_idle();
      if (c == 0) drive_load_use(1'b0);
      if (c == 4) begin idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; end
      if (c == 6) begin idex_memread = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7; end
      @(negedge clk);
      e0 = model_exp(0); e1 = model_exp(1); total += 2;
      if (obs[0] !== e0) begin bad++; $display("FAIL load_use_a c%0d got=%h exp=%h", c, obs[0], e0); end
      if (obs[1] !== e1) begin bad++; $display("FAIL load_use_b c%0d got=%h exp=%h", c, obs[1], e1); end
      if (c == 0) begin
        total++;
        if (a_pcw !== 1'b0 || a_bub !== 1'b1) begin
          bad++; $display("FAIL load_use_gate got pcw=%b bub=%b exp pcw=0 bub=1", a_pcw, a_bub);
        end
      end
      clock_edge();
    end
  endtask

  task automatic test_forwarding();
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      exmem_rd = 5'd5; memwb_rd = 5'd5; idex_rs = 5'd5;
      exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
      if (c == 1) exmem_regwrite = 1'b0;
      if (c == 2) begin exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs = 5'd0; end
      if (c == 3) begin idex_rs = 5'd9; idex_rt = 5'd5; exmem_regwrite = 1'b0; end
      @(negedge clk);
      e0 = model_exp(0); e1 = model_exp(1); total += 2;
      if (obs[0] !== e0) begin bad++; $display("FAIL fwd_a_inst c%0d got=%h exp=%h", c, obs[0], e0); end
      if (obs[1] !== e1) begin bad++; $display("FAIL fwd_b_inst c%0d got=%h exp=%h", c, obs[1], e1); end
      clock_edge();
    end
  endtask

  // Load-use and taken branch together, then a branch in the middle of a long stall.
  task automatic test_pcsrc_priority();
    for (int c = 0; c < 10; c++) begin
      drive_idle();
      if (c == 0) drive_load_use(1'b1);
      if (c == 4) drive_load_use(1'b0);
      if (c == 5) mem_pcsrc = 1'b1;
      if (c == 6) drive_load_use(1'b1);
      if (c == 7) drive_load_use(1'b0);
      @(negedge clk);
      e0 = model_exp(0); e1 = model_exp(1); total += 2;
      if (obs[0] !== e0) begin bad++; $display("FAIL pcsrc_a c%0d got=%h exp=%h", c, obs[0], e0); end
      if (obs[1] !== e1) begin bad++; $display("FAIL pcsrc_b c%0d got=%h exp=%h", c, obs[1], e1); end
      clock_edge();
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 2; r++) begin
      drive_idle();
      if (r == 0) drive_load_use(1'b0); else mem_pcsrc = 1'b1;
      clock_edge();
      clock_edge();
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      e0 = model_exp(0); e1 = model_exp(1); total += 2;
      if (obs[0] !== e0) begin bad++; $display("FAIL reset_mid_a r%0d got=%h exp=%h", r, obs[0], e0); end
      if (obs[1] !== e1) begin bad++; $display("FAIL reset_mid_b r%0d got=%h exp=%h", r, obs[1], e1); end
      drive_idle();
      clock_edge();
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        e0 = model_exp(0); e1 = model_exp(1); total += 2;
        if (obs[0] !== e0) begin bad++; $display("FAIL rel_a r%0d c%0d got=%h exp=%h", r, c, obs[0], e0); end
        if (obs[1] !== e1) begin bad++; $display("FAIL rel_b r%0d c%0d got=%h exp=%h", r, c, obs[1], e1); end
        clock_edge();
      end
    end
  endtask

  task automatic test_saturation();
    drive_load_use(1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e0 = model_exp(0); e1 = model_exp(1); total += 2;
      if (obs[0] !== e0) begin bad++; $display("FAIL sat_a c%0d got=%h exp=%h", c, obs[0], e0); end
      if (obs[1] !== e1) begin bad++; $display("FAIL sat_b c%0d got=%h exp=%h", c, obs[1], e1); end
      clock_edge();
    end
    drive_idle();
    @(negedge clk);
    total++;
    if (b_sc !== 4'hF) begin bad++; $display("FAIL sat_hold got=%h exp=f", b_sc); end
    clock_edge();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ifid_rs        = 5'($urandom_range(0, 3));
      ifid_rt        = 5'($urandom_range(0, 3));
      idex_rs        = 5'($urandom_range(0, 3));
      idex_rt        = 5'($urandom_range(0, 3));
      exmem_rd       = 5'($urandom_range(0, 3));
      memwb_rd       = 5'($urandom_range(0, 3));
      idex_memread   = 1'($urandom_range(0, 1));
      exmem_regwrite = 1'($urandom_range(0, 1));
      memwb_regwrite = 1'($urandom_range(0, 1));
      mem_pcsrc      = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      e0 = model_exp(0); e1 = model_exp(1); total += 2;
      if (obs[0] !== e0) begin bad++; $display("FAIL rand_a c%0d got=%h exp=%h", c, obs[0], e0); end
      if (obs[1] !== e1) begin bad++; $display("FAIL rand_b c%0d got=%h exp=%h", c, obs[1], e1); end
      clock_edge();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_pcsrc_priority();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
